// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Constants shared by the convolutional encoder and the Viterbi decoder, so
// both ends of the link use the same trellis and the same polynomial pair.
//   K        constraint length
//   SW       trellis state width (K-1)
//   G0 / G1  generator polynomials (octal 17 / 15)
//   enc_state_e      encoder frame FSM states
//   trellis_state_t  shift-register / trellis state type
// ---------------------------------------------------------------------------
package viterbi_pkg;

  localparam int K  = 4;
  localparam int SW = K - 1;

  localparam logic [K-1:0] G0 = 4'b1111;
  localparam logic [K-1:0] G1 = 4'b1101;

  typedef logic [SW-1:0] trellis_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } enc_state_e;

endpackage

// File: rtl/conv_enc_core.sv
// ---------------------------------------------------------------------------
// conv_enc_core
// One trellis step of the rate-1/2 encoder, purely combinational.
//   u       in   1    current input bit
//   s       in   SW   shift register, s[0] is the oldest bit
//   sym     out  2    code symbol {g0, g1}
//   s_next  out  SW   shift register after this step
// ---------------------------------------------------------------------------
module conv_enc_core
  import viterbi_pkg::*;
(
  input  logic           u,
  input  trellis_state_t s,
  output logic [1:0]     sym,
  output trellis_state_t s_next
);

  logic [K-1:0] w;

  // The new bit sits in the MSB so the oldest bit falls off at w[0].
  assign w      = {u, s};
  assign sym    = {^(w & G0), ^(w & G1)};
  assign s_next = w[K-1:1];

endmodule

// File: rtl/conv_encoder.sv
// ---------------------------------------------------------------------------
// conv_encoder
// Rate-1/2, K=4 convolutional encoder with frame sequencing. Each accepted
// info bit yields one registered 2-bit symbol the following cycle; every
// frame is closed with K-1 zero tail bits so the trellis ends in state 0.
//   clk         in   1  clock
//   rst         in   1  synchronous reset, active-high
//   start       in   1  begin a frame (only honoured in IDLE)
//   bit_in      in   1  info bit
//   bit_valid   in   1  bit_in is valid
//   bit_ready   out  1  bit_in is accepted this cycle
//   sym_out     out  2  code symbol {g0, g1}
//   sym_valid   out  1  sym_out valid (decoder enable)
//   busy        out  1  frame in progress
//   frame_done  out  1  one-cycle pulse after the last tail symbol
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; no bits accepted
// DATA  | accepting FRAME_LEN info bits, bubbles allowed
// TAIL  | flushing K-1 zero bits on consecutive cycles
// DONE  | frame finished; frame_done is registered for the next cycle
// ---------------------------------------------------------------------------
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(K);

  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TAIL_LOAD = TW'(K - 2);

  enc_state_e     state;
  enc_state_e     state_nx;
  trellis_state_t s;
  trellis_state_t s_next;
  logic [CW-1:0]  bit_cnt;
  logic [TW-1:0]  tail_cnt;
  logic [1:0]     sym;
  logic           enc_step;
  logic           enc_u;
  logic           last_bit;
  logic           tail_last;
  logic           data_accept;

  assign last_bit    = (bit_cnt == LAST_IDX);
  assign tail_last   = (tail_cnt == '0);
  assign data_accept = (state == DATA) && bit_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start)                  state_nx = DATA;
      DATA: if (bit_valid && last_bit)  state_nx = TAIL;
      TAIL: if (tail_last)              state_nx = DONE;
      DONE:                             state_nx = IDLE;
      default:                          state_nx = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    bit_ready = 1'b0;
    busy      = 1'b1;
    enc_step  = 1'b0;
    enc_u     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      DATA: begin
        bit_ready = 1'b1;
        enc_step  = bit_valid;
        enc_u     = bit_in;
      end
      TAIL: begin
        enc_step = 1'b1;
        enc_u    = 1'b0;
      end
      DONE: begin
        enc_step = 1'b0;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  conv_enc_core u_core (
    .u      (enc_u),
    .s      (s),
    .sym    (sym),
    .s_next (s_next)
  );

  // Shift register and symbol output. sym_out holds through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s         <= '0;
      sym_out   <= 2'b00;
      sym_valid <= 1'b0;
    end else begin
      sym_valid <= enc_step;
      if (state == IDLE && start) begin
        s <= '0;
      end else if (enc_step) begin
        s <= s_next;
      end
      if (enc_step) begin
        sym_out <= sym;
      end
    end
  end

  // Info-bit counter; start is only seen in IDLE so it cannot disturb a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (state == IDLE && start) begin
      bit_cnt <= '0;
    end else if (data_accept) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Tail down-counter: loaded with K-2 as the last info bit goes in, so the
  // terminal count is reached on the (K-1)th tail cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_cnt <= '0;
    end else if (data_accept && last_bit) begin
      tail_cnt <= TAIL_LOAD;
    end else if (state == TAIL && !tail_last) begin
      tail_cnt <= tail_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
module tb_conv_encoder;

  localparam int LA = 4;
  localparam int LB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s   [2];
  logic       start_s [2];
  logic       bit_s   [2];
  logic       valid_s [2];
  logic       ready_s [2];
  logic       sval_s  [2];
  logic       busy_s  [2];
  logic       fdone_s [2];
  logic [1:0] sym_s   [2];

  conv_encoder #(.FRAME_LEN(LA)) dut_a (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .bit_in(bit_s[0]),
    .bit_valid(valid_s[0]), .bit_ready(ready_s[0]), .sym_out(sym_s[0]),
    .sym_valid(sval_s[0]), .busy(busy_s[0]), .frame_done(fdone_s[0])
  );

  conv_encoder #(.FRAME_LEN(LB)) dut_b (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .bit_in(bit_s[1]),
    .bit_valid(valid_s[1]), .bit_ready(ready_s[1]), .sym_out(sym_s[1]),
    .sym_valid(sval_s[1]), .busy(busy_s[1]), .frame_done(fdone_s[1])
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: frame progress as counts of bits taken and tails sent,
  // symbols computed as mod-2 sums over the last bits entered.
  bit       m_active [2];
  int       m_taken  [2];
  int       m_tails  [2];
  int       h1 [2];
  int       h2 [2];
  int       h3 [2];
  bit [1:0] m_sym    [2];
  bit       m_sval   [2];
  bit       m_fdone  [2];

  int done_cnt [2];
  int done_cyc [2];
  int mon_idx = 0;
  int       log_cyc [$];
  bit [1:0] log_sym [$];

  function automatic int frame_len(input int i);
    return (i == 0) ? LA : LB;
  endfunction

  task automatic chk_bits(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_encode(input int i, input int u);
    int g0;
    int g1;
    // G0 = 1111 taps all four bits, G1 = 1101 skips the bit two back.
    g0 = (u + h1[i] + h2[i] + h3[i]) % 2;
    g1 = (u + h1[i] + h3[i]) % 2;
    m_sym[i]  = {g0[0], g1[0]};
    m_sval[i] = 1'b1;
    h3[i] = h2[i];
    h2[i] = h1[i];
    h1[i] = u;
  endtask

  task automatic model_step(input int i);
    if (rst_s[i]) begin
      m_active[i] = 1'b0;
      m_taken[i]  = 0;
      m_tails[i]  = 0;
      h1[i] = 0; h2[i] = 0; h3[i] = 0;
      m_sym[i]   = 2'b00;
      m_sval[i]  = 1'b0;
      m_fdone[i] = 1'b0;
    end else begin
      m_sval[i]  = 1'b0;
      m_fdone[i] = 1'b0;
      if (!m_active[i]) begin
        if (start_s[i]) begin
          m_active[i] = 1'b1;
          m_taken[i]  = 0;
          m_tails[i]  = 0;
          h1[i] = 0; h2[i] = 0; h3[i] = 0;
        end
      end else if (m_taken[i] < frame_len(i)) begin
        if (valid_s[i]) begin
          model_encode(i, int'(bit_s[i]));
          m_taken[i]++;
        end
      end else if (m_tails[i] < 3) begin
        model_encode(i, 0);
        m_tails[i]++;
      end else begin
        m_fdone[i]  = 1'b1;
        m_active[i] = 1'b0;
      end
    end
  endtask

  // Compare every cycle on the falling edge, then advance the model with
  // the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      chk_bits($sformatf("sym_valid[%0d]", i), {1'b0, sval_s[i]}, {1'b0, m_sval[i]});
      chk_bits($sformatf("sym_out[%0d]", i), sym_s[i], m_sym[i]);
      chk_bits($sformatf("bit_ready[%0d]", i), {1'b0, ready_s[i]},
               {1'b0, m_active[i] && (m_taken[i] < frame_len(i))});
      chk_bits($sformatf("busy[%0d]", i), {1'b0, busy_s[i]}, {1'b0, m_active[i]});
      chk_bits($sformatf("frame_done[%0d]", i), {1'b0, fdone_s[i]}, {1'b0, m_fdone[i]});
      if (fdone_s[i] === 1'b1) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      if (i == mon_idx && sval_s[i] === 1'b1) begin
        log_cyc.push_back(cyc);
        log_sym.push_back(sym_s[i]);
      end
      model_step(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic st, input logic v, input logic b);
    start_s[i] = st;
    valid_s[i] = v;
    bit_s[i]   = b;
    tick();
  endtask

  task automatic wait_done(input int i, input int d0, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt[i] == d0 && n < budget) begin
      tick();
      n++;
    end
    chk_int(name, int'(done_cnt[i] != d0), 1);
  endtask

  function automatic bit [1:0] log_at(input int k);
    return (k < log_sym.size()) ? log_sym[k] : 2'b00;
  endfunction

  function automatic int cyc_at(input int k);
    return (k < log_cyc.size()) ? log_cyc[k] : -1000;
  endfunction

  bit [1:0] exp_a [7] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
  int       bits_a [4] = '{1, 0, 1, 1};

  task automatic check_frame_a(input string tag);
    chk_int({tag, "_count"}, log_sym.size(), 7);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (k >= log_sym.size() || log_sym[k] != exp_a[k]) begin
        failures++;
        $display("FAIL %s_sym%0d: got %b expected %b", tag, k, log_at(k), exp_a[k]);
      end
    end
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; start_s[i] = 1'b0; valid_s[i] = 1'b0; bit_s[i] = 1'b0;
    end
    tick();
    tick();
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    tick();

    // Frame of 1,0,1,1 with bit_valid held high.
    mon_idx = 0;
    log_sym.delete(); log_cyc.delete();
    d0 = done_cnt[0];
    drive(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive(0, 1'b0, 1'b1, bits_a[k][0]);
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_done(0, d0, 30, "t1_done");
    check_frame_a("t1");
    chk_int("t1_contiguous", cyc_at(6) - cyc_at(0), 6);
    chk_int("t1_done_lag", done_cyc[0] - cyc_at(6), 1);
    chk_bits("t1_busy_after", {1'b0, busy_s[0]}, 2'b00);

    // Two-cycle bubble between bit 1 and bit 2.
    log_sym.delete(); log_cyc.delete();
    d0 = done_cnt[0];
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) drive(0, 1'b0, 1'b1, bits_a[k][0]);
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_done(0, d0, 30, "t2_done");
    check_frame_a("t2");
    chk_int("t2_gap", cyc_at(1) - cyc_at(0), 3);
    chk_int("t2_tail_contig", cyc_at(6) - cyc_at(3), 3);

    // start held high during DATA and TAIL must not restart the frame.
    log_sym.delete(); log_cyc.delete();
    d0 = done_cnt[0];
    drive(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive(0, 1'b1, 1'b1, bits_a[k][0]);
    for (int k = 0; k < 3; k++) drive(0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_done(0, d0, 30, "t3_done");
    check_frame_a("t3");

    // Reset after two bits, then a fresh frame starting with bit 1.
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b0, 1'b1, 1'b1);
    rst_s[0] = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b1);
    rst_s[0] = 1'b0;
    chk_bits("t4_rst_sym", sym_s[0], 2'b00);
    chk_bits("t4_rst_flags", {sval_s[0] | fdone_s[0], busy_s[0] | ready_s[0]}, 2'b00);
    log_sym.delete(); log_cyc.delete();
    d0 = done_cnt[0];
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) drive(0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);
    wait_done(0, d0, 30, "t4_done");
    chk_int("t4_count", log_sym.size(), 7);
    chk_bits("t4_first_sym", log_at(0), 2'b11);

    // FRAME_LEN=1 with a single zero bit.
    mon_idx = 1;
    log_sym.delete(); log_cyc.delete();
    d0 = done_cnt[1];
    drive(1, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b1, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    wait_done(1, d0, 30, "t6_done");
    chk_int("t6_count", log_sym.size(), 4);
    for (int k = 0; k < 4; k++) chk_bits($sformatf("t6_sym%0d", k), log_at(k), 2'b00);
    chk_int("t6_done_lag", done_cyc[1] - cyc_at(3), 1);

    // Random traffic on both encoders, checked cycle by cycle against the model.
    mon_idx = 2;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        rst_s[i]   = ($urandom_range(0, 299) == 0);
        start_s[i] = ($urandom_range(0, 5) == 0);
        valid_s[i] = ($urandom_range(0, 3) != 0);
        bit_s[i]   = $urandom_range(0, 1) == 1;
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b0; start_s[i] = 1'b0; valid_s[i] = 1'b0; bit_s[i] = 1'b0;
    end
    for (int n = 0; n < 20; n++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
